imem_loader: RTL

// Writes a program into instruction memory, the write side of the instruction

---
 rtl/imem_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: length header, then big-endian words.
// Holds the CPU in reset until the full image has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic        restart;
  logic [15:0] full_len;
  logic        len_bad;
  logic        last_word;

  assign byte_ready = (state == S_LEN_HI) ||
                      (state == S_LEN_LO) ||
                      (state == S_BYTE);
  assign mem_we     = (state == S_WRITE);
  assign cpu_hold   = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);

  assign xfer      = byte_valid && byte_ready;
  assign restart   = start && ((state == S_IDLE) ||
                               (state == S_DONE) ||
                               (state == S_ERROR));
  assign full_len  = {len[15:8], byte_data};
  assign len_bad   = (full_len == 16'd0) ||
                     (32'(full_len) > 32'(MAX_WORDS));
  assign last_word = (16'(word_cnt + 16'd1) == len);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (restart) state_nxt = S_LEN_HI;
      S_LEN_HI:
        if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO:
        if (xfer) state_nxt = len_bad ? S_ERROR : S_BYTE;
      S_BYTE:
        if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE:
        state_nxt = last_word ? S_DONE : S_BYTE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      if (restart) begin
        word_cnt <= '0;
        byte_idx <= '0;
        mem_addr <= BASE_ADDR;
      end
      if (xfer && state == S_LEN_HI) len[15:8] <= byte_data;
      if (xfer && state == S_LEN_LO) len[7:0]  <= byte_data;
      if (xfer && state == S_BYTE) begin
        mem_wdata <= {mem_wdata[23:0], byte_data};
        byte_idx  <= byte_idx + 2'd1;
      end
      // Address advances after the strobe so the write sees a stable address
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + 16'd1;
        mem_addr <= mem_addr + ADDR_WIDTH'(4);
      end
    end
  end

endmodule
